// File: rtl/text_pkg.sv
// Shared text-screen constants and types for the writer and the renderer.
// TEXT_WRITER_LINE_CLEAR_EN adds the per-row LINECLR state.
package text_pkg;

    localparam int COLS_DEF  = 40;
    localparam int ROWS_DEF  = 30;
    localparam int CELLS_DEF = COLS_DEF * ROWS_DEF;

    localparam logic [7:0] BLANK_DEF = 8'h20;
    localparam logic [7:0] CH_BS     = 8'h08;
    localparam logic [7:0] CH_LF     = 8'h0A;
    localparam logic [7:0] CH_FF     = 8'h0C;
    localparam logic [7:0] CH_CR     = 8'h0D;

    typedef enum logic [1:0] {
        S_IDLE,
`ifdef TEXT_WRITER_LINE_CLEAR_EN
        S_CLEAR,
        S_LINECLR
`else
        S_CLEAR
`endif
    } state_t;

    typedef enum logic [2:0] {
        OP_NONE,
        OP_ADV,
        OP_CR,
        OP_LF,
        OP_BS,
        OP_HOME
    } cur_op_t;

    function automatic logic is_print(input logic [7:0] c);
        return (c >= 8'h20) && (c <= 8'h7E);
    endfunction

endpackage

// File: rtl/text_cursor.sv
// Cursor position registers, advance/wrap/backspace arithmetic and
// the linear cell address of the cursor.
module text_cursor
    import text_pkg::*;
#(
    parameter int COLS = COLS_DEF,
    parameter int ROWS = ROWS_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  cur_op_t     op_i,
    output logic [5:0]  col_o,
    output logic [4:0]  row_o,
    output logic [11:0] addr_o
);

    logic [5:0] col_q, col_d;
    logic [4:0] row_q, row_d;
    logic [4:0] row_nxt;

    // No scrolling: the bottom row wraps to the top.
    assign row_nxt = (row_q == 5'(ROWS - 1)) ? 5'd0 : row_q + 5'd1;

    always_comb begin
        col_d = col_q;
        row_d = row_q;
        unique case (op_i)
            OP_ADV: begin
                if (col_q == 6'(COLS - 1)) begin
                    col_d = 6'd0;
                    row_d = row_nxt;
                end else begin
                    col_d = col_q + 6'd1;
                end
            end
            OP_CR: col_d = 6'd0;
            OP_LF: begin
                col_d = 6'd0;
                row_d = row_nxt;
            end
            OP_BS: begin
                if (col_q != 6'd0) col_d = col_q - 6'd1;
            end
            OP_HOME: begin
                col_d = 6'd0;
                row_d = 5'd0;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            col_q <= 6'd0;
            row_q <= 5'd0;
        end else begin
            col_q <= col_d;
            row_q <= row_d;
        end
    end

    assign col_o  = col_q;
    assign row_o  = row_q;
    assign addr_o = 12'(row_q) * 12'(COLS) + 12'(col_q);

endmodule

// File: rtl/text_writer.sv
// Character-stream writer for the text display memory.
// TEXT_WRITER_LINE_CLEAR_EN blanks each row as the cursor enters it.
module text_writer
    import text_pkg::*;
#(
    parameter int         COLS  = COLS_DEF,
    parameter int         ROWS  = ROWS_DEF,
    parameter logic [7:0] BLANK = BLANK_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    input  logic [7:0]  in_char,
    output logic        in_ready,
    output logic        mem_we,
    output logic [11:0] mem_addr,
    output logic [7:0]  mem_data,
    output logic [5:0]  cursor_col,
    output logic [4:0]  cursor_row,
    output logic        busy
);

    localparam logic [11:0] CELLS = 12'(COLS * ROWS);

    state_t      state_q, state_d;
    logic [11:0] cnt_q, cnt_d;
    logic        we_q, we_d;
    logic [11:0] addr_q, addr_d;
    logic [7:0]  data_q, data_d;
    cur_op_t     op;
    logic [11:0] cur_addr;
    logic        acc;

    assign in_ready = (state_q == S_IDLE) && !reset;
    assign acc      = in_valid && in_ready;

    text_cursor #(
        .COLS (COLS),
        .ROWS (ROWS)
    ) u_cursor (
        .clk    (clk),
        .reset  (reset),
        .op_i   (op),
        .col_o  (cursor_col),
        .row_o  (cursor_row),
        .addr_o (cur_addr)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        we_d    = 1'b0;
        addr_d  = addr_q;
        data_d  = data_q;
        op      = OP_NONE;
        unique case (state_q)
            S_IDLE: begin
                if (acc) begin
                    if (is_print(in_char)) begin
                        we_d   = 1'b1;
                        addr_d = cur_addr;
                        data_d = in_char;
                        op     = OP_ADV;
`ifdef TEXT_WRITER_LINE_CLEAR_EN
                        if (cursor_col == 6'(COLS - 1)) begin
                            state_d = S_LINECLR;
                            cnt_d   = 12'd0;
                        end
`endif
                    end else begin
                        case (in_char)
                            CH_CR: op = OP_CR;
                            CH_LF: begin
                                op = OP_LF;
`ifdef TEXT_WRITER_LINE_CLEAR_EN
                                state_d = S_LINECLR;
                                cnt_d   = 12'd0;
`endif
                            end
                            CH_BS: op = OP_BS;
                            CH_FF: begin
                                state_d = S_CLEAR;
                                cnt_d   = 12'd0;
                            end
                            default: ;
                        endcase
                    end
                end
            end
            S_CLEAR: begin
                if (cnt_q == CELLS) begin
                    state_d = S_IDLE;
                    op      = OP_HOME;
                end else begin
                    we_d   = 1'b1;
                    addr_d = cnt_q;
                    data_d = BLANK;
                    cnt_d  = cnt_q + 12'd1;
                end
            end
`ifdef TEXT_WRITER_LINE_CLEAR_EN
            // Cursor already sits at column 0 of the new row.
            S_LINECLR: begin
                if (cnt_q == 12'(COLS)) begin
                    state_d = S_IDLE;
                end else begin
                    we_d   = 1'b1;
                    addr_d = cur_addr + cnt_q;
                    data_d = BLANK;
                    cnt_d  = cnt_q + 12'd1;
                end
            end
`endif
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= 12'd0;
            we_q    <= 1'b0;
            addr_q  <= 12'd0;
            data_q  <= 8'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
        end
    end

    assign mem_we   = we_q;
    assign mem_addr = addr_q;
    assign mem_data = data_q;
    assign busy     = (state_q != S_IDLE);

endmodule

// File: tb/tb_text_writer.sv
// Self-checking bench for text_writer: vector table, cursor model
// and a write scoreboard fed at acceptance time.
module tb_text_writer;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic [7:0]  in_char = 8'h00;
    logic        in_ready;
    logic        mem_we;
    logic [11:0] mem_addr;
    logic [7:0]  mem_data;
    logic [5:0]  cursor_col;
    logic [4:0]  cursor_row;
    logic        busy;

    int tests = 0;
    int fails = 0;
    int mcol = 0;
    int mrow = 0;
    logic [19:0] q[$];

    always #5 clk = ~clk;

    text_writer dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_char    (in_char),
        .in_ready   (in_ready),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_data   (mem_data),
        .cursor_col (cursor_col),
        .cursor_row (cursor_row),
        .busy       (busy)
    );

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Scoreboard consumer
    always @(negedge clk) begin
        if (mem_we === 1'b1) begin
            if (q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_write: addr %0d data %0h, none expected",
                         mem_addr, mem_data);
            end else begin
                logic [19:0] e;
                e = q.pop_front();
                chk("sb_addr", int'(mem_addr), int'(e[19:8]));
                chk("sb_data", int'(mem_data), int'(e[7:0]));
            end
        end
    end

    task automatic push_wr(input int a, input int d);
        q.push_back({12'(a), 8'(d)});
    endtask

    task automatic model(input logic [7:0] c);
        bit nr = 0;
        if (c >= 8'h20 && c <= 8'h7E) begin
            push_wr(mrow * 40 + mcol, c);
            if (mcol == 39) begin
                mcol = 0;
                mrow = (mrow == 29) ? 0 : mrow + 1;
                nr = 1;
            end else begin
                mcol++;
            end
        end else if (c == 8'h0D) begin
            mcol = 0;
        end else if (c == 8'h0A) begin
            mcol = 0;
            mrow = (mrow == 29) ? 0 : mrow + 1;
            nr = 1;
        end else if (c == 8'h08) begin
            if (mcol > 0) mcol--;
        end else if (c == 8'h0C) begin
            for (int i = 0; i < 1200; i++) push_wr(i, 8'h20);
            mcol = 0;
            mrow = 0;
        end
`ifdef TEXT_WRITER_LINE_CLEAR_EN
        if (nr) for (int i = 0; i < 40; i++) push_wr(mrow * 40 + i, 8'h20);
`else
        if (nr) mcol = mcol;
`endif
    endtask

    // Drives one character; returns #1 after the accepting edge.
    task automatic send(input logic [7:0] c);
        int t = 0;
        @(negedge clk);
        while (!in_ready && t < 3000) begin
            @(negedge clk);
            t++;
        end
        if (!in_ready) chk("send_timeout", 0, 1);
        in_valid = 1'b1;
        in_char  = c;
        model(c);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int t = 0;
        while (!in_ready && t < 3000) begin
            @(negedge clk);
            t++;
        end
        chk("idle_timeout", int'(in_ready), 1);
    endtask

    task automatic drain();
        int t = 0;
        while (q.size() != 0 && t < 3000) begin
            @(negedge clk);
            t++;
        end
        chk("drain", q.size(), 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset    = 1'b1;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        chk("rst_in_ready_low", int'(in_ready), 0);
        @(negedge clk);
        reset = 1'b0;
        q.delete();
        mcol = 0;
        mrow = 0;
    endtask

    task automatic chk_cur(input string name, input int col, input int row);
        chk({name, "_col"}, int'(cursor_col), col);
        chk({name, "_row"}, int'(cursor_row), row);
    endtask

    typedef struct {
        logic [7:0]  ch;
        logic        we;
        logic [11:0] addr;
        int          col;
        int          row;
    } vec_t;

    vec_t vt[10];

    initial begin
        vt[0] = '{8'h41, 1'b1, 12'd0,  1, 0};
        vt[1] = '{8'h42, 1'b1, 12'd1,  2, 0};
        vt[2] = '{8'h0D, 1'b0, 12'd0,  0, 0};
        vt[3] = '{8'h43, 1'b1, 12'd0,  1, 0};
        vt[4] = '{8'h08, 1'b0, 12'd0,  0, 0};
        vt[5] = '{8'h08, 1'b0, 12'd0,  0, 0};
        vt[6] = '{8'h01, 1'b0, 12'd0,  0, 0};
        vt[7] = '{8'h0A, 1'b0, 12'd0,  0, 1};
        vt[8] = '{8'h44, 1'b1, 12'd40, 1, 1};
        vt[9] = '{8'h7E, 1'b1, 12'd41, 2, 1};

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready_in_reset", int'(in_ready), 0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("rst_ready", int'(in_ready), 1);
        chk("rst_we", int'(mem_we), 0);
        chk("rst_addr", int'(mem_addr), 0);
        chk("rst_data", int'(mem_data), 0);
        chk("rst_busy", int'(busy), 0);
        chk_cur("rst", 0, 0);

        // Vector table; writes must appear in the cycle after acceptance
        for (int i = 0; i < 10; i++) begin
            send(vt[i].ch);
            chk("vec_we", int'(mem_we), int'(vt[i].we));
            if (vt[i].we) begin
                chk("vec_addr", int'(mem_addr), int'(vt[i].addr));
                chk("vec_data", int'(mem_data), int'(vt[i].ch));
            end
            chk_cur("vec", vt[i].col, vt[i].row);
        end
        drain();

        // Row wrap after 40 printable characters
        do_reset();
        for (int i = 0; i < 40; i++) begin
            send(8'(8'h61 + (i % 26)));
            if (i == 39) chk("row_last_addr", int'(mem_addr), 39);
        end
        chk_cur("row_wrap", 0, 1);
        send(8'h5A);
        wait_idle();
        drain();

        // Bottom-row wrap and no-effect codes
        do_reset();
        for (int i = 0; i < 29; i++) send(8'h0A);
        for (int i = 0; i < 5; i++) send(8'h78);
        wait_idle();
        drain();
        chk_cur("pos_5_29", 5, 29);
        send(8'h0A);
        chk("lf_no_write", int'(mem_we), 0);
        chk_cur("lf_wrap", 0, 0);
        wait_idle();
        send(8'h08);
        chk_cur("bs_col0", 0, 0);
        send(8'h01);
        chk("ctl_no_write", int'(mem_we), 0);
        chk_cur("ctl", 0, 0);
        drain();

        // LF from (3,7): line clear of row 8 only when configured
        do_reset();
        for (int i = 0; i < 7; i++) send(8'h0A);
        for (int i = 0; i < 3; i++) send(8'h2E);
        wait_idle();
        drain();
        begin
            int nwr = 0;
            send(8'h0A);
            for (int t = 0; t < 60; t++) begin
                @(negedge clk);
                if (mem_we) nwr++;
            end
`ifdef TEXT_WRITER_LINE_CLEAR_EN
            chk("lineclr_writes", nwr, 40);
`else
            chk("lineclr_writes", nwr, 0);
`endif
            chk("lineclr_ready", int'(in_ready), 1);
            chk_cur("lineclr", 0, 8);
        end
        drain();

        // Full clear
        send(8'h51);
        wait_idle();
        begin
            int nwr = 0;
            int rdy = 0;
            int t = 0;
            send(8'h0C);
            chk("ff_busy", int'(busy), 1);
            while (busy && t < 1400) begin
                @(negedge clk);
                if (busy && in_ready) rdy++;
                if (mem_we) nwr++;
                t++;
            end
            chk("ff_writes", nwr, 1200);
            chk("ff_ready_low", rdy, 0);
            @(negedge clk);
            chk_cur("ff_home", 0, 0);
            chk("ff_ready_after", int'(in_ready), 1);
        end
        drain();

        // Held in_valid during clear: consumed once, after clear ends
        send(8'h0C);
        begin
            int waited = 0;
            int accs = 0;
            bit r;
            in_valid = 1'b1;
            in_char  = 8'h5A;
            model(8'h5A);
            while (accs == 0 && waited < 1400) begin
                @(negedge clk);
                r = in_ready;
                @(posedge clk);
                #1;
                if (r) begin
                    accs++;
                    in_valid = 1'b0;
                end
                waited++;
            end
            in_valid = 1'b0;
            chk("hold_accepts", accs, 1);
            chk("hold_waited", int'(waited > 1000), 1);
            chk("hold_we", int'(mem_we), 1);
            chk("hold_addr", int'(mem_addr), 0);
            chk_cur("hold", 1, 0);
        end
        wait_idle();
        drain();

        // Reset while clearing aborts the sequence
        send(8'h41);
        send(8'h0C);
        begin
            int n = 0;
            int t = 0;
            int extra = 0;
            while (n < 600 && t < 1400) begin
                @(posedge clk);
                #1;
                if (mem_we) n++;
                t++;
            end
            chk("abort_reach600", n, 600);
            reset = 1'b1;
            @(posedge clk);
            #1;
            chk("abort_we", int'(mem_we), 0);
            chk("abort_ready_rst", int'(in_ready), 0);
            @(negedge clk);
            reset = 1'b0;
            q.delete();
            mcol = 0;
            mrow = 0;
            for (int k = 0; k < 30; k++) begin
                @(negedge clk);
                if (mem_we) extra++;
            end
            chk("abort_no_writes", extra, 0);
            chk("abort_busy", int'(busy), 0);
            chk("abort_ready", int'(in_ready), 1);
            chk_cur("abort", 0, 0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/text_writer.md
TEXT_WRITER -- requirements
Module: text_writer

Interface
REQ-001 Parameter COLS, default 40: text columns per row.
REQ-002 Parameter ROWS, default 30: text rows per screen.
REQ-003 Parameter BLANK, default 8'h20: code written to cleared cells.
REQ-004 clk  input  1  sole clock; all logic on its rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 in_valid  input  1  in_char holds a character to consume.
REQ-007 in_char  input  8  character code (printable or control).
REQ-008 in_ready  output  1  writer accepts in_char this cycle.
REQ-009 mem_we  output  1  display-memory write strobe, one cycle per cell.
REQ-010 mem_addr  output  12  display-memory cell address, row*COLS+col.
REQ-011 mem_data  output  8  character code written at mem_addr.
REQ-012 cursor_col  output  6  current cursor column, 0..COLS-1.
REQ-013 cursor_row  output  5  current cursor row, 0..ROWS-1.
REQ-014 busy  output  1  a clear sequence is in progress.

Function
REQ-015 The block SHALL be the writer of the display memory read by the text renderer: cell address = row*COLS+col, range 0..COLS*ROWS-1 (0..1199 at defaults).
REQ-016 The FSM SHALL have states IDLE, CLEAR (full screen) and, when configured, LINECLR; in_ready = (state==IDLE) and not reset.
REQ-017 A character SHALL be accepted on a cycle with in_valid && in_ready; its write (if any) appears on mem_we/mem_addr/mem_data in the following cycle, as registered outputs, for exactly one cycle.
REQ-018 Back-to-back accepted printable characters SHALL produce one write per cycle (throughput 1).
REQ-019 Printable 8'h20..8'h7E: write at cursor, then col+1; at col COLS-1, col 0 and row+1.
REQ-020 8'h0D (CR): col 0, row unchanged, no write.
REQ-021 8'h0A (LF): col 0, row+1, no write.
REQ-022 8'h08 (BS): col-1, no write; at col 0 no change.
REQ-023 8'h0C (FF): enter CLEAR; write BLANK to addresses 0..COLS*ROWS-1 ascending, one per cycle; then cursor (0,0), return to IDLE; busy high from the cycle after acceptance through the last write.
REQ-024 All other codes SHALL be consumed with no write and no cursor change.
REQ-025 Row advance from ROWS-1 SHALL wrap to row 0 (no scrolling).
REQ-026 Cursor outputs SHALL update on the same edge that registers the corresponding write.
REQ-027 mem_we SHALL be 0 in every cycle not defined above.

Reset
REQ-028 On reset: state IDLE, cursor (0,0), mem_we 0, mem_addr 0, mem_data 0, busy 0; in_ready 0 during the reset cycle, 1 the cycle after.
REQ-029 Reset during CLEAR or LINECLR SHALL abort it immediately; no further writes issue.

Configuration
REQ-030 Macro TEXT_WRITER_LINE_CLEAR_EN defined: each time the cursor enters a new row (wrap, LF, or row-29 wrap), enter LINECLR and write BLANK to all COLS cells of that row, col 0..COLS-1, busy high, in_ready low, then return to IDLE with cursor at (new row, 0).
REQ-031 Macro undefined: LINECLR state absent; row changes cause no writes.

Structure
REQ-032 Package text_pkg SHALL hold COLS/ROWS/CELLS defaults, BLANK, control-code constants (CR, LF, BS, FF) and the FSM state typedef; shared with the renderer.
REQ-033 Sub-module text_cursor SHALL hold cursor col/row registers and advance/wrap/backspace arithmetic plus address computation; text_writer holds FSM and memory port.

Verification
REQ-034 Reset, then "A","B" on consecutive cycles -> writes (0,8'h41),(1,8'h42) on consecutive cycles, cursor (2,0).
REQ-035 40 printable chars from (0,0) -> last write addr 39, cursor (0,1); next char -> addr 40.
REQ-036 Cursor (5,29), LF -> cursor (0,0), no write; BS at col 0 -> no change; 8'h01 -> no write, no change.
REQ-037 FF -> 1200 writes of 8'h20, addr 0..1199 contiguous, in_ready low throughout, cursor (0,0) after; reset asserted at write 600 -> no write after reset cycle, cursor (0,0).
REQ-038 With TEXT_WRITER_LINE_CLEAR_EN, cursor (3,7), LF -> 40 writes of 8'h20 at addr 320..359, then in_ready high, cursor (0,8); without macro -> no writes.
REQ-039 in_valid held high with in_ready low (during CLEAR) -> character not consumed until in_ready returns, then accepted exactly once.
